// File: rtl/drum_voice_player.sv
// drum_voice_player: one-shot drum voice. A new valid key press latches the
// keymapper's base address and streams SAMPLE_LEN words from sample memory
// through a rd/ack handshake. One word is presented per sample_tick.
module drum_voice_player #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int SAMPLE_LEN = 32768
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        keycode,
  input  logic [ADDR_W-1:0] note_addr,
  input  logic              invalid_note,
  input  logic              sample_tick,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] sample_out,
  output logic              playing,
  output logic [7:0]        underrun_cnt
);

  localparam int OFF_W = $clog2(SAMPLE_LEN);
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(SAMPLE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } state_t;

  state_t            state_reg;
  logic [7:0]        key_prev_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] pend_base_reg;
  logic [OFF_W-1:0]  offset_reg;
  logic [DATA_W-1:0] sample_buf_reg;
  logic              pending_reg;

  logic              trig;
  logic [OFF_W-1:0]  offset_next;
  logic [ADDR_W-1:0] restart_base;

  // A trigger is any change to a valid, non-zero drum key; releases (key 0)
  // and held keys never trigger.
  assign trig         = (keycode != key_prev_reg) && !invalid_note && (keycode != 8'd0);
  assign offset_next  = offset_reg + OFF_W'(1);
  // A trigger coincident with the ack is newer than any latched pending one.
  assign restart_base = trig ? note_addr : pend_base_reg;

  // Voice FSM with registered memory request and audio outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg      <= IDLE;
      key_prev_reg   <= '0;
      base_reg       <= '0;
      pend_base_reg  <= '0;
      offset_reg     <= '0;
      sample_buf_reg <= '0;
      pending_reg    <= 1'b0;
      mem_addr       <= '0;
      mem_rd         <= 1'b0;
      sample_out     <= '0;
      playing        <= 1'b0;
      underrun_cnt   <= '0;
    end else begin
      key_prev_reg <= keycode;
      case (state_reg)
        IDLE: begin
          mem_rd  <= 1'b0;
          playing <= 1'b0;
          // Silence is output on every tick while idle, even on a trigger tick.
          if (sample_tick) sample_out <= '0;
          if (trig) begin
            base_reg   <= note_addr;
            offset_reg <= '0;
            mem_addr   <= note_addr;
            mem_rd     <= 1'b1;
            playing    <= 1'b1;
            state_reg  <= FETCH;
          end
        end

        FETCH: begin
          // A tick with no word ready is an underrun; sample_out holds.
          if (sample_tick && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
          if (mem_ack) begin
            if (pending_reg || trig) begin
              // Retriggered during the read: drop the word, restart the note.
              base_reg    <= restart_base;
              offset_reg  <= '0;
              mem_addr    <= restart_base;
              pending_reg <= 1'b0;
            end else begin
              sample_buf_reg <= mem_rdata;
              mem_rd         <= 1'b0;
              state_reg      <= READY;
            end
          end else if (trig) begin
            // The handshake is never abandoned; remember the newest note.
            pending_reg   <= 1'b1;
            pend_base_reg <= note_addr;
          end
        end

        READY: begin
          if (sample_tick) sample_out <= sample_buf_reg;
          if (trig) begin
            base_reg   <= note_addr;
            offset_reg <= '0;
            mem_addr   <= note_addr;
            mem_rd     <= 1'b1;
            state_reg  <= FETCH;
          end else if (sample_tick) begin
            if (offset_reg == LAST_OFF) begin
              playing   <= 1'b0;
              state_reg <= IDLE;
            end else begin
              offset_reg <= offset_next;
              mem_addr   <= base_reg + ADDR_W'(offset_next);
              mem_rd     <= 1'b1;
              state_reg  <= FETCH;
            end
          end
        end

        default: begin
          mem_rd    <= 1'b0;
          playing   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drum_voice_player.sv
// tb_drum_voice_player: directed plus randomized stimulus for the drum voice,
// checked every cycle against a behavioural voice model. The memory responder
// is driven from the model's view of the outstanding read.
module tb_drum_voice_player;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int LEN    = 4;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [7:0]        keycode;
  logic [ADDR_W-1:0] note_addr;
  logic              invalid_note;
  logic              sample_tick;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] sample_out;
  logic              playing;
  logic [7:0]        underrun_cnt;

  drum_voice_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_LEN(LEN)) dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .note_addr(note_addr),
    .invalid_note(invalid_note), .sample_tick(sample_tick), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .sample_out(sample_out), .playing(playing), .underrun_cnt(underrun_cnt)
  );

  initial forever #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Voice model: active voice, whether a fetched word is waiting, next index.
  bit m_active, m_word_ready, m_pend;
  int m_idx, m_base, m_pend_base, m_buf, m_out, m_under, m_keyprev, m_wait;

  int lat  = 2;
  int tper = 4;
  int cyc  = 0;
  int addr_log[$];
  bit watch_en = 1'b0;
  int watch_val = 0;
  bit stale_seen = 1'b0;

  function automatic logic [15:0] mem_word(input int a);
    logic [31:0] x;
    x = (32'(a) & 32'hFFFFF) * 32'd40503 + 32'h00013579;
    return x[21:6];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_word_ready = 0; m_pend = 0;
    m_idx = 0; m_base = 0; m_pend_base = 0; m_buf = 0;
    m_out = 0; m_under = 0; m_keyprev = 0; m_wait = 0;
  endtask

  // One clock: drive inputs, answer memory, advance model, compare outputs.
  task automatic step(input bit tick);
    bit trig, fetching, ack;
    int rdata;
    @(negedge Clk);
    sample_tick = tick;
    trig     = (int'(keycode) != m_keyprev) && !invalid_note && (keycode != 8'd0);
    fetching = m_active && !m_word_ready;
    ack      = fetching && (m_wait + 1 >= lat);
    rdata    = int'(mem_word(m_base + m_idx));
    mem_ack  = ack;
    mem_rdata = ack ? 16'(rdata) : 16'($urandom);
    if (ack) addr_log.push_back(int'(mem_addr));
    @(posedge Clk);
    if (!m_active) begin
      if (tick) m_out = 0;
      if (trig) begin
        m_active = 1; m_word_ready = 0; m_base = int'(note_addr); m_idx = 0; m_wait = 0;
      end
    end else if (!m_word_ready) begin
      if (tick && m_under < 255) m_under++;
      if (ack) begin
        if (m_pend || trig) begin
          m_base = trig ? int'(note_addr) : m_pend_base;
          m_idx = 0; m_pend = 0; m_wait = 0;
        end else begin
          m_buf = rdata; m_word_ready = 1;
        end
      end else begin
        m_wait++;
        if (trig) begin m_pend = 1; m_pend_base = int'(note_addr); end
      end
    end else begin
      if (tick) m_out = m_buf;
      if (trig) begin
        m_base = int'(note_addr); m_idx = 0; m_word_ready = 0; m_wait = 0;
      end else if (tick) begin
        if (m_idx == LEN - 1) m_active = 0;
        else begin m_idx++; m_word_ready = 0; m_wait = 0; end
      end
    end
    m_keyprev = int'(keycode);
    cyc++;
    #1;
    check("playing", playing, m_active);
    check("mem_rd", mem_rd, m_active && !m_word_ready);
    if (m_active && !m_word_ready) check("mem_addr", mem_addr, (m_base + m_idx) & 32'hFFFFF);
    check("sample_out", sample_out, m_out);
    check("underrun_cnt", underrun_cnt, m_under);
    if (watch_en && int'(sample_out) == watch_val) stale_seen = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step((cyc % tper) == 0);
  endtask

  task automatic press(input logic [7:0] k, input bit inv, input logic [19:0] a, input bit tick);
    keycode = k; invalid_note = inv; note_addr = a;
    step(tick);
  endtask

  task automatic release_key();
    press(8'd0, 1'b1, 20'h0, 1'b0);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int g = 0;
    while (m_active && g < limit) begin run(1); g++; end
    check(tag, g < limit, 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_playing"}, playing, 0);
    check({tag, "_mem_rd"}, mem_rd, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_sample_out"}, sample_out, 0);
    check({tag, "_underrun"}, underrun_cnt, 0);
  endtask

  initial begin
    int g;
    int wrap_exp[4];
    int retrig_exp[7];
    wrap_exp   = '{32'hFFFFE, 32'hFFFFF, 32'h00000, 32'h00001};
    retrig_exp = '{32'h79230, 32'h79231, 32'h79232, 32'h71130, 32'h71131, 32'h71132, 32'h71133};

    // Power-up reset.
    Reset = 1'b1; keycode = 8'd0; note_addr = '0; invalid_note = 1'b1;
    sample_tick = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    @(negedge Clk); @(negedge Clk);
    check_outputs_zero("reset");
    Reset = 1'b0;
    model_reset();

    // Basic playback of key 8, ack latency 2.
    lat = 2; tper = 4;
    addr_log.delete();
    press(8'd8, 1'b0, 20'h79230, 1'b0);
    wait_idle("play1_timeout", 200);
    check("play1_log_len", addr_log.size(), LEN);
    for (int i = 0; i < LEN; i++) check("play1_addr", addr_log[i], 32'h79230 + i);
    check("play1_last_word", sample_out, mem_word(32'h79233));
    check("play1_playing_low", playing, 0);
    run(tper);
    check("play1_silence", sample_out, 0);

    // Held key then release: exactly one playback.
    release_key();
    addr_log.delete();
    press(8'd8, 1'b0, 20'h79230, 1'b0);
    run(10 * tper);
    release_key();
    run(20);
    check("hold_one_shot", addr_log.size(), LEN);

    // Invalid key: nothing happens.
    addr_log.delete();
    press(8'd99, 1'b1, 20'h12345, 1'b0);
    run(20);
    check("invalid_no_read", addr_log.size(), 0);
    check("invalid_playing", playing, 0);
    check("invalid_silence", sample_out, 0);

    // Retrigger while the offset-2 read is outstanding.
    lat = 3; tper = 4;
    addr_log.delete();
    press(8'd8, 1'b0, 20'h79230, 1'b0);
    g = 0;
    while (!(m_active && !m_word_ready && m_idx == 2 && m_wait == 0) && g < 200) begin run(1); g++; end
    check("retrig_reach", g < 200, 1'b1);
    watch_val = int'(mem_word(32'h79232)); watch_en = 1'b1; stale_seen = 1'b0;
    press(8'd26, 1'b0, 20'h71130, 1'b0);
    g = 0;
    while (addr_log.size() < 3 && g < 50) begin run(1); g++; end
    check("retrig_next_addr", mem_addr, 32'h71130);
    wait_idle("retrig_timeout", 300);
    watch_en = 1'b0;
    check("retrig_stale_word", stale_seen, 1'b0);
    check("retrig_log_len", addr_log.size(), 7);
    for (int i = 0; i < 7; i++) check("retrig_addr", addr_log[i], retrig_exp[i]);

    // Underruns with slow memory.
    release_key();
    lat = 3; tper = 2;
    press(8'd8, 1'b0, 20'h79230, 1'b0);
    wait_idle("under_timeout", 200);
    check("under_nonzero", underrun_cnt != 8'd0, 1'b1);
    release_key();
    lat = 320; tper = 1;
    press(8'd8, 1'b0, 20'h79230, 1'b0);
    run(330);
    check("under_saturated", underrun_cnt, 255);
    release_key();
    wait_idle("sat_timeout", 3000);

    // Trigger and tick together in idle, then address wrap.
    lat = 2; tper = 4;
    addr_log.delete();
    press(8'd5, 1'b0, 20'hFFFFE, 1'b1);
    check("trig_tick_clear", sample_out, 0);
    wait_idle("wrap_timeout", 200);
    check("wrap_log_len", addr_log.size(), LEN);
    for (int i = 0; i < LEN; i++) check("wrap_addr", addr_log[i], wrap_exp[i]);

    // Asynchronous reset in the middle of a fetch.
    lat = 5;
    press(8'd6, 1'b0, 20'h00100, 1'b0);
    g = 0;
    while (!(m_active && !m_word_ready && m_wait == 2) && g < 50) begin run(1); g++; end
    check("midfetch_reach", mem_rd, 1'b1);
    @(negedge Clk);
    mem_ack = 1'b0; sample_tick = 1'b0;
    keycode = 8'd0; invalid_note = 1'b1; note_addr = '0;
    #2 Reset = 1'b1;
    #1 check_outputs_zero("async_reset");
    model_reset();
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;
    run(10);

    // Randomized key presses, latencies and tick rates.
    for (int it = 0; it < 20; it++) begin
      logic [7:0] k;
      lat  = (it == 0) ? 1 : int'($urandom_range(1, 4));
      tper = int'($urandom_range(2, 7));
      k    = 8'($urandom_range(0, 120));
      press(k, (k % 5 == 0) || (k == 8'd0), 20'($urandom), 1'b0);
      run(int'($urandom_range(3, 30)));
    end
    release_key();
    wait_idle("random_timeout", 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/drum_voice_player.md
Name: drum_voice_player

Overview:
- One-shot drum playback voice, directly downstream of the drum keymapper.
- Consumes the keymapper's 20-bit sample base address and invalid flag, plus the raw keycode.
- On each new valid key press, streams SAMPLE_LEN 16-bit words from sample memory over a request/ack handshake.
- Presents one word per audio sample_tick to the mixer/DAC path.

Parameters:
- ADDR_W, 20, sample-memory word address width.
- DATA_W, 16, sample word width (signed PCM).
- SAMPLE_LEN, 32768, words played per trigger; must be ≥2.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- keycode  in  8  raw keyboard keycode, also feeding the keymapper.
- note_addr  in  ADDR_W  sample base address from the keymapper.
- invalid_note  in  1  keymapper flag: keycode is not a drum key.
- sample_tick  in  1  one-Clk pulse at the audio sample rate.
- mem_addr  out  ADDR_W  sample-memory read address.
- mem_rd  out  1  read request.
- mem_ack  in  1  one-Clk pulse; mem_rdata is valid in that cycle.
- mem_rdata  in  DATA_W  read data.
- sample_out  out  DATA_W  current output sample, registered.
- playing  out  1  high while a voice is active.
- underrun_cnt  out  8  saturating count of ticks missed while fetching.

Behaviour:
- Reset (async):
  - state=IDLE, key_prev=0, sample_out=0, mem_rd=0, mem_addr=0, playing=0, underrun_cnt=0, pending=0.
- Trigger:
  - trig = (keycode != key_prev) && !invalid_note.
  - key_prev <= keycode every cycle.
  - Key release (keycode→0) never triggers.
  - Holding a key gives exactly one trigger.
  - Playback is one-shot: release does not stop it.
- States: IDLE, FETCH, READY.
- IDLE:
  - playing=0.
  - On sample_tick: sample_out<=0.
  - On trig: base<=note_addr, offset<=0, go FETCH next cycle.
  - trig wins over a simultaneous tick; sample_out still clears to 0.
- FETCH:
  - mem_rd=1, mem_addr=(base+offset) mod 2^ADDR_W.
  - mem_rd and mem_addr stay stable until mem_ack.
  - On mem_ack: buf<=mem_rdata, go READY.
  - Zero-wait ack is allowed: mem_rd may deassert the cycle after it asserts.
- READY:
  - mem_rd=0.
  - On sample_tick: sample_out<=buf.
    - If offset==SAMPLE_LEN-1: go IDLE.
    - Else offset<=offset+1, go FETCH.
- Output latency:
  - First word reaches sample_out on the first sample_tick after its mem_ack.
  - sample_out changes only on sample_tick cycles.
- playing:
  - Registered; high from the cycle after trig until the cycle after the last word is output.
- Underrun:
  - A sample_tick while in FETCH: sample_out holds its value, underrun_cnt increments, saturating at 255.
  - The pending fetch still completes normally.
- Retrigger mid-play:
  - Trig in READY: base/offset reload, buf is discarded, go FETCH. sample_out keeps its last value until the next tick.
  - Trig in FETCH: the handshake is never abandoned.
    - Latch pending=1 and the new base.
    - On mem_ack, discard the data, reload offset=0 and base, clear pending, stay in FETCH with the new address.
  - A trig in the same cycle as mem_ack is treated as pending.
  - Multiple trigs before ack: the latest note_addr wins.
- Address wrap: base+offset wraps modulo 2^ADDR_W, with no error.
- invalid_note and note_addr are sampled only in the trig cycle.

Test Plan:
- Reset, then keycode 0→8 (note_addr=0x79230), memory ack latency 2 → mem_addr steps 0x79230, 0x79231, …
  - sample_out equals memory contents on successive ticks.
  - playing drops after SAMPLE_LEN ticks (use SAMPLE_LEN=4 in the bench).
  - The next tick outputs 0.
- Hold keycode 8 for 10 ticks, then release to 0 → exactly one playback; the release produces no trigger and no mem_rd.
- Keycode 99 (invalid_note=1) → no mem_rd, playing stays 0, sample_out stays 0.
- During play of 0x79230 at offset 2, press keycode 26 (0x71130) while mem_rd is waiting on ack →
  - the outstanding read completes and its data never appears on sample_out;
  - the next mem_addr is 0x71130.
- Ack latency of 3 ticks → underrun_cnt increments per missed tick and sample_out holds. Force 300 underruns → underrun_cnt=255.
- note_addr=0xFFFFE with SAMPLE_LEN=4 → mem_addr sequence 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
  - Assert Reset mid-FETCH → all outputs zero immediately, state IDLE.
